// File: rtl/mips_io_pkg.sv
// Shared definitions for the I/O page sequencer: state encoding, page base,
// error read-back pattern and default device-field geometry.
package mips_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ERR  = 2'd2,
        ST_DONE = 2'd3
    } io_state_t;

    // Base of the I/O page; the sequencer only sees the low offset bits.
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    // Value returned to the CPU when an access fails (timeout or unmapped).
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam int DEF_DEV_SHIFT = 4;
    localparam int DEF_DEV_BITS  = 3;

endpackage

// File: rtl/io_dev_decode.sv
// Device decoder: turns the page offset above the register field into a
// "mapped" flag and a one-hot chip select. Purely combinational.
module io_dev_decode #(
    parameter int FIELD_W  = 6,
    parameter int DEV_BITS = 3,
    localparam int N_DEV   = 2**DEV_BITS
) (
    input  logic [FIELD_W-1:0] dev_field,
    output logic               mapped,
    output logic [N_DEV-1:0]   cs
);

    // Any bit above the device index means the offset points past the last device.
    generate
        if (FIELD_W > DEV_BITS) begin : g_hi
            assign mapped = ~|dev_field[FIELD_W-1:DEV_BITS];
        end else begin : g_no_hi
            assign mapped = 1'b1;
        end
    endgenerate

    // One-hot select from the device index bits.
    always_comb begin
        cs = '0;
        cs[dev_field[DEV_BITS-1:0]] = 1'b1;
    end

endmodule

// File: rtl/io_bus_sequencer.sv
// Multi-cycle sequencer for CPU loads/stores to the I/O page. Stalls the
// pipeline while one req/ack transaction runs on the peripheral bus, with a
// one-hot device select, a timeout and a sticky error flag.
//
// Peripheral handshake: pio_req is raised in BUS and held, together with
// pio_we/pio_cs/pio_addr/pio_wdata, until the cycle in which pio_ack is seen
// or the timeout fires. A transfer completes on the first rising edge where
// pio_req && pio_ack; pio_ack at any other time is ignored.
module io_bus_sequencer
    import mips_io_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int DEV_SHIFT = DEF_DEV_SHIFT,
    parameter int DEV_BITS  = DEF_DEV_BITS,
    parameter int TIMEOUT   = 15,
    localparam int N_DEV    = 2**DEV_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              err_clr,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rvalid,
    output logic              pio_req,
    output logic              pio_we,
    output logic [N_DEV-1:0]  pio_cs,
    output logic [DEV_SHIFT-1:0] pio_addr,
    output logic [DATA_W-1:0] pio_wdata,
    input  logic              pio_ack,
    input  logic [DATA_W-1:0] pio_rdata,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    io_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DEV_SHIFT-1:0]  off_q;
    logic [N_DEV-1:0]      cs_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    logic                  start;
    logic                  err_set;
    logic                  dec_mapped;
    logic [N_DEV-1:0]      dec_cs;

    io_dev_decode #(
        .FIELD_W  (ADDR_W - DEV_SHIFT),
        .DEV_BITS (DEV_BITS)
    ) u_decode (
        .dev_field (io_addr[ADDR_W-1:DEV_SHIFT]),
        .mapped    (dec_mapped),
        .cs        (dec_cs)
    );

    // Next-state and per-state outputs; stall rises in the same cycle as the strobe.
    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        io_rvalid = 1'b0;
        pio_req   = 1'b0;
        start     = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_read || io_write) begin
                    cpu_stall = 1'b1;
                    start     = 1'b1;
                    err_set   = io_read && io_write;
                    state_d   = dec_mapped ? ST_BUS : ST_ERR;
                end
            end
            ST_BUS: begin
                pio_req   = 1'b1;
                cpu_stall = 1'b1;
                if (pio_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                cpu_stall = 1'b1;
                err_set   = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                io_rvalid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture the access parameters when a strobe is accepted in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off_q   <= '0;
            cs_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (start) begin
            off_q   <= io_addr[DEV_SHIFT-1:0];
            cs_q    <= dec_cs;
            we_q    <= io_write;
            wdata_q <= io_wdata;
        end
    end

    // BUS cycle counter: cleared on the way into BUS, counts every BUS cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 cnt_q <= '0;
        else if (start)            cnt_q <= '0;
        else if (state_q == ST_BUS) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Load result: peripheral data on ack (writes return 0), error pattern on failure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state_q == ST_BUS && pio_ack) begin
            rdata_q <= we_q ? '0 : pio_rdata;
        end else if (state_q == ST_ERR) begin
            rdata_q <= DATA_W'(ERR_DATA);
        end
    end

    // Sticky error flag; a same-cycle set beats err_clr.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
    end

    assign pio_we    = pio_req & we_q;
    assign pio_cs    = pio_req ? cs_q : '0;
    assign pio_addr  = off_q;
    assign pio_wdata = wdata_q;
    assign io_rdata  = rdata_q;
    assign bus_err   = err_q;
    assign dbg_state = state_q;

endmodule
